test_status_monitor: RTL and testbench
======================================

# test_status_monitor

Synthesizable, parametrised end-of-test monitor for the RV64 core. It snoops the register-file write port and shadows three watched architectural registers: test number, done flag and pass flag. It resolves the run to PASS, FAIL or TIMEOUT, and reports the result with a one-cycle strobe, a latched test number and a cycle count. It sits beside `soc` in the bench and in FPGA builds, and replaces hierarchical peeking into the register file.

## Interface
Parameters:
- `XLEN`, 64, register data width.
- `TNUM_REG`, 3, register index holding the current test number.
- `DONE_REG`, 26, register index whose value 1 signals end of test.
- `PASS_REG`, 27, register index whose value 1 signals success.
- `TIMEOUT_CYCLES`, 1_000_000, watchdog limit in cycles; 0 disables the watchdog.
- `CNT_W`, 32, width of the cycle counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous restart pulse.
- `rf_we`  in  1  register-file write enable.
- `rf_waddr`  in  5  register-file write index.
- `rf_wdata`  in  XLEN  register-file write data.
- `done`  out  1  level; high in any terminal state.
- `pass`  out  1  level; high in PASS only.
- `fail`  out  1  level; high in FAIL only.
- `timeout`  out  1  level; high in TIMEOUT only.
- `report`  out  1  one-cycle pulse on entry to a terminal state.
- `test_num`  out  XLEN  test-number shadow, frozen once terminal.
- `cycles`  out  CNT_W  cycles spent in RUN, frozen once terminal.

## Operation
- Shadows: there are three XLEN registers (tnum, dn, ps).
  - Each loads `rf_wdata` when `rf_we` is high and `rf_waddr` matches its index.
  - A write with `rf_waddr`==0 is ignored, even if a parameter is set to 0.
  - Shadows hold their value once the FSM is terminal.
- FSM states are RUN, PASS, FAIL and TIMEOUT. RUN is entered when reset is released.
- Transitions out of RUN, evaluated on the registered shadows:
  - dn==1 and ps==1 → PASS.
  - dn==1 and ps!=1 → FAIL.
  - dn==1 takes priority over timeout in the same cycle.
  - Otherwise, `TIMEOUT_CYCLES`!=0 and cycles==`TIMEOUT_CYCLES`-1 → TIMEOUT.
- Terminal states are sticky until `rst` or `clear`.
- dn is compared against 1 over its full XLEN. Any other nonzero value is not done.
- Counter: `cycles` increments each cycle in RUN, saturates at all-ones and holds in terminal states.
- `clear`: zeros the shadows and counter and forces RUN on the next edge. It takes priority over a same-cycle write and over a same-cycle transition.
- `report` is high for exactly the first cycle the FSM is in a terminal state.

## Timing
- Reset values: state=RUN; shadows=0; `cycles`=0; `done`/`pass`/`fail`/`timeout`/`report`=0; `test_num`=0.
- Write latency: a write at edge N is visible on `test_num` after edge N.
- Done latency: a done write at edge N moves the FSM to a terminal state at edge N+1. `done` and `report` go high after N+1.
- A pass-register write at edge N counts toward the verdict. A pass-register write at edge N+1 is too late.
- Watchdog: with T=`TIMEOUT_CYCLES`, `timeout` rises after the T-th edge following reset release, and `cycles`=T.
- Reset asserted mid-run clears everything asynchronously, with no `report` pulse.
- All outputs are registered; there is no combinational path from `rf_*` to any output.

## Structure
- Package `tsm_pkg` holds:
  - the state enum `tsm_state_e` (RUN, PASS, FAIL, TIMEOUT);
  - default register indices `TSM_TNUM_REG`, `TSM_DONE_REG` and `TSM_PASS_REG`;
  - `TSM_DONE_VAL`=1 and `TSM_PASS_VAL`=1.
- Sub-module `tsm_shadow_reg`, parametrised by `XLEN` and `IDX`, is instantiated three times. It provides the write match, load, clear and freeze.
- The FSM, counter and report pulse live in the top module.

## Test plan
- Pass: write x3=5, x27=1, then x26=1 → `pass`=1, `report` pulses once, `test_num`=5. `cycles` is frozen at the run length.
- Fail: x3=7, x27=0, x26=1 → `fail`=1, `test_num`=7. A later write x27=1 leaves `fail`=1.
- Same-edge writes: x27=1 and x26=1 on the same edge are not possible on one port, so write x27 first with x26 on the next edge → PASS. Separately, x26=1 then x27=1 one cycle later → FAIL.
- Timeout: `TIMEOUT_CYCLES`=16 with no writes → `timeout` after 16 edges, `cycles`=16. Done at cycle 15 → PASS/FAIL, not TIMEOUT.
- Filtering: x26=2, x0 writes and a write with `rf_we`=0 → stays RUN. A subsequent x26=1 → terminal.
- Restart: from PASS, pulse `clear` → RUN with `cycles`=0 and shadows 0. Asserting `rst` mid-run returns all outputs to reset values with no `report` pulse.

Source files
------------

// File: rtl/tsm_pkg.sv
// tsm_pkg: shared types and constants for the end-of-test status monitor.
//   tsm_state_e   : monitor FSM states (RUN and the three terminal verdicts)
//   TSM_*_REG     : default architectural register indices that are watched
//   TSM_*_VAL     : register values that signal end of test and success
//   tsm_is_terminal() : true for any state other than RUN
package tsm_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } tsm_state_e;

  localparam int TSM_TNUM_REG = 3;
  localparam int TSM_DONE_REG = 26;
  localparam int TSM_PASS_REG = 27;

  localparam int TSM_DONE_VAL = 1;
  localparam int TSM_PASS_VAL = 1;

  function automatic logic tsm_is_terminal(input tsm_state_e st);
    logic term;
    case (st)
      ST_RUN:  term = 1'b0;
      default: term = 1'b1;
    endcase
    return term;
  endfunction

endpackage

// File: rtl/tsm_shadow_reg.sv
// tsm_shadow_reg: shadow copy of one architectural register, snooped from the
// register-file write port.
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : synchronous restart, zeros the shadow (beats a write)
//   freeze        : hold the current value (monitor has reached a verdict)
//   rf_we/rf_waddr/rf_wdata : register-file write port being snooped
//   value         : registered shadow value
module tsm_shadow_reg
  import tsm_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int IDX  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            freeze,
  input  logic            rf_we,
  input  logic [4:0]      rf_waddr,
  input  logic [XLEN-1:0] rf_wdata,
  output logic [XLEN-1:0] value
);

  localparam logic [4:0] IDX_ADDR = 5'(IDX);

  logic load_s;

  // x0 is hard-wired zero in the core, so a write to it never reaches a
  // shadow even if a watched index is configured as 0.
  assign load_s = rf_we && (rf_waddr == IDX_ADDR) && (rf_waddr != 5'd0) && !freeze;

  // Shadow register: reset/clear to zero, load on matching write, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (load_s) begin
      value <= rf_wdata;
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/test_status_monitor.sv
// test_status_monitor: end-of-test monitor for the RV64 core. Shadows the
// test-number, done and pass registers from the register-file write port and
// resolves the run to PASS, FAIL or TIMEOUT.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : synchronous restart pulse (back to RUN, shadows/counter zeroed)
//   rf_we/rf_waddr/rf_wdata : snooped register-file write port
//   done       : high in any terminal state
//   pass/fail/timeout : one-hot verdict levels
//   report     : one-cycle pulse on entry to a terminal state
//   test_num   : test-number shadow, frozen once terminal
//   cycles     : cycles spent in RUN (saturating), frozen once terminal
module test_status_monitor
  import tsm_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TNUM_REG       = TSM_TNUM_REG,
  parameter int DONE_REG       = TSM_DONE_REG,
  parameter int PASS_REG       = TSM_PASS_REG,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             rf_we,
  input  logic [4:0]       rf_waddr,
  input  logic [XLEN-1:0]  rf_wdata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             report,
  output logic [XLEN-1:0]  test_num,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [XLEN-1:0]  DONE_VAL = XLEN'(TSM_DONE_VAL);
  localparam logic [XLEN-1:0]  PASS_VAL = XLEN'(TSM_PASS_VAL);
  localparam logic             WDOG_EN  = (TIMEOUT_CYCLES != 0);
  // Compare against T-1 so the verdict lands on the T-th RUN edge, together
  // with the counter reaching T.
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  tsm_state_e      state_r;
  logic            freeze_s;
  logic [XLEN-1:0] dn;
  logic [XLEN-1:0] ps;
  logic [CNT_W-1:0] cycles_inc_s;

  assign freeze_s     = tsm_is_terminal(state_r);
  assign cycles_inc_s = (cycles == CNT_MAX) ? cycles : (cycles + {{(CNT_W-1){1'b0}}, 1'b1});

  tsm_shadow_reg #(.XLEN(XLEN), .IDX(TNUM_REG)) u_tnum (
    .clk(clk), .rst(rst), .clear(clear), .freeze(freeze_s),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .value(test_num)
  );

  tsm_shadow_reg #(.XLEN(XLEN), .IDX(DONE_REG)) u_done (
    .clk(clk), .rst(rst), .clear(clear), .freeze(freeze_s),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .value(dn)
  );

  tsm_shadow_reg #(.XLEN(XLEN), .IDX(PASS_REG)) u_pass (
    .clk(clk), .rst(rst), .clear(clear), .freeze(freeze_s),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .value(ps)
  );

  // Verdict FSM with cycle counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
      cycles  <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
      report  <= 1'b0;
    end else if (clear) begin
      state_r <= ST_RUN;
      cycles  <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
      report  <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          cycles <= cycles_inc_s;
          // Done is checked first so it wins over a same-cycle watchdog expiry.
          if (dn == DONE_VAL) begin
            done   <= 1'b1;
            report <= 1'b1;
            if (ps == PASS_VAL) begin
              state_r <= ST_PASS;
              pass    <= 1'b1;
            end else begin
              state_r <= ST_FAIL;
              fail    <= 1'b1;
            end
          end else if (WDOG_EN && (cycles == WDOG_LAST)) begin
            state_r <= ST_TIMEOUT;
            done    <= 1'b1;
            timeout <= 1'b1;
            report  <= 1'b1;
          end else begin
            report <= 1'b0;
          end
        end
        default: begin
          // Terminal states are sticky; only the entry pulse is dropped.
          report <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_status_monitor.sv
// tb_test_status_monitor: directed self-checking bench for test_status_monitor
// (XLEN=64, TIMEOUT_CYCLES=16, default watched registers x3/x26/x27).
module tb_test_status_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        done, pass, fail, timeout, report;
  logic [63:0] test_num;
  logic [31:0] cycles;

  int n_checks = 0;
  int n_fail   = 0;

  test_status_monitor #(
    .XLEN(64), .TNUM_REG(3), .DONE_REG(26), .PASS_REG(27),
    .TIMEOUT_CYCLES(16), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .report(report), .test_num(test_num), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given write-port values, then release the port.
  task automatic wr(input logic we, input logic [4:0] a, input logic [63:0] d);
    rf_we = we; rf_waddr = a; rf_wdata = d;
    @(posedge clk); #1;
    rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 64'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 64'd0;
    idle(2);
    // Reset values
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_pass", {63'd0, pass}, 64'd0);
    chk("rst_fail", {63'd0, fail}, 64'd0);
    chk("rst_timeout", {63'd0, timeout}, 64'd0);
    chk("rst_report", {63'd0, report}, 64'd0);
    chk("rst_test_num", test_num, 64'd0);
    chk("rst_cycles", {32'd0, cycles}, 64'd0);
    rst = 1'b0;

    // PASS: x3=5, x27=1, x26=1
    wr(1'b1, 5'd3, 64'd5);
    chk("pass_tnum_latency", test_num, 64'd5);
    chk("pass_cycles1", {32'd0, cycles}, 64'd1);
    wr(1'b1, 5'd27, 64'd1);
    wr(1'b1, 5'd26, 64'd1);
    chk("pass_done_latency", {63'd0, done}, 64'd0);
    idle(1);
    chk("pass_pass", {63'd0, pass}, 64'd1);
    chk("pass_done", {63'd0, done}, 64'd1);
    chk("pass_fail", {63'd0, fail}, 64'd0);
    chk("pass_report", {63'd0, report}, 64'd1);
    chk("pass_cycles", {32'd0, cycles}, 64'd4);
    idle(1);
    chk("pass_report_once", {63'd0, report}, 64'd0);
    chk("pass_cycles_frozen", {32'd0, cycles}, 64'd4);
    wr(1'b1, 5'd3, 64'd9);
    chk("pass_tnum_frozen", test_num, 64'd5);
    chk("pass_sticky", {63'd0, pass}, 64'd1);

    // Restart from PASS; a same-edge write loses to clear
    clear = 1'b1; rf_we = 1'b1; rf_waddr = 5'd3; rf_wdata = 64'd8;
    @(posedge clk); #1;
    clear = 1'b0; rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 64'd0;
    chk("clr_done", {63'd0, done}, 64'd0);
    chk("clr_pass", {63'd0, pass}, 64'd0);
    chk("clr_cycles", {32'd0, cycles}, 64'd0);
    chk("clr_tnum", test_num, 64'd0);
    idle(1);
    chk("clr_run_count", {32'd0, cycles}, 64'd1);
    chk("clr_dn_zero", {63'd0, done}, 64'd0);
    do_clear();

    // FAIL: x3=7, x27=0, x26=1; later x27=1 does not change verdict
    wr(1'b1, 5'd3, 64'd7);
    wr(1'b1, 5'd27, 64'd0);
    wr(1'b1, 5'd26, 64'd1);
    idle(1);
    chk("fail_fail", {63'd0, fail}, 64'd1);
    chk("fail_pass", {63'd0, pass}, 64'd0);
    chk("fail_report", {63'd0, report}, 64'd1);
    chk("fail_tnum", test_num, 64'd7);
    wr(1'b1, 5'd27, 64'd1);
    chk("fail_sticky", {63'd0, fail}, 64'd1);
    chk("fail_no_pass", {63'd0, pass}, 64'd0);
    do_clear();

    // x27 then x26 on consecutive edges -> PASS
    wr(1'b1, 5'd27, 64'd1);
    wr(1'b1, 5'd26, 64'd1);
    idle(1);
    chk("order_pass", {63'd0, pass}, 64'd1);
    do_clear();

    // x26 then x27 one cycle later -> FAIL (pass write too late)
    wr(1'b1, 5'd26, 64'd1);
    wr(1'b1, 5'd27, 64'd1);
    chk("late_fail", {63'd0, fail}, 64'd1);
    chk("late_no_pass", {63'd0, pass}, 64'd0);
    chk("late_report", {63'd0, report}, 64'd1);
    do_clear();

    // Filtering: x26=2, x0 write, disabled write -> stays RUN
    wr(1'b1, 5'd26, 64'd2);
    wr(1'b1, 5'd0, 64'd1);
    wr(1'b0, 5'd26, 64'd1);
    idle(1);
    chk("filt_run", {63'd0, done}, 64'd0);
    wr(1'b1, 5'd26, 64'd1);
    idle(1);
    chk("filt_done", {63'd0, done}, 64'd1);
    chk("filt_fail", {63'd0, fail}, 64'd1);
    chk("filt_cycles", {32'd0, cycles}, 64'd6);
    do_clear();

    // Watchdog: 16 edges with no writes
    idle(15);
    chk("wd_before", {63'd0, timeout}, 64'd0);
    chk("wd_cycles15", {32'd0, cycles}, 64'd15);
    idle(1);
    chk("wd_timeout", {63'd0, timeout}, 64'd1);
    chk("wd_done", {63'd0, done}, 64'd1);
    chk("wd_report", {63'd0, report}, 64'd1);
    chk("wd_cycles", {32'd0, cycles}, 64'd16);
    idle(1);
    chk("wd_report_once", {63'd0, report}, 64'd0);
    chk("wd_cycles_frozen", {32'd0, cycles}, 64'd16);
    do_clear();

    // Done visible in the same cycle the watchdog would fire -> FAIL wins
    idle(14);
    wr(1'b1, 5'd26, 64'd1);
    chk("wdp_cycles15", {32'd0, cycles}, 64'd15);
    idle(1);
    chk("wdp_fail", {63'd0, fail}, 64'd1);
    chk("wdp_no_timeout", {63'd0, timeout}, 64'd0);
    chk("wdp_cycles", {32'd0, cycles}, 64'd16);
    do_clear();

    // Reset asserted mid-run, just before a verdict would land
    wr(1'b1, 5'd3, 64'd4);
    wr(1'b1, 5'd26, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tnum", test_num, 64'd0);
    chk("arst_cycles", {32'd0, cycles}, 64'd0);
    @(posedge clk); #1;
    chk("arst_report", {63'd0, report}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    idle(1);
    chk("arst_run_cycles", {32'd0, cycles}, 64'd1);
    chk("arst_run_done", {63'd0, done}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
